// File: rtl/xor_mismatch_monitor.sv
// xor_mismatch_monitor
//
// Consumes the registered per-cycle mismatch bit (a^b) from the upstream XOR
// stage and keeps running statistics about it:
//   - the current run of consecutive mismatches (saturating),
//   - the total number of mismatches since reset/clear (saturating),
//   - the number of mismatches in the most recently completed window of
//     WINDOW valid samples,
//   - a sticky alarm raised when a mismatch run reaches RUN_THRESH.
//
// Ports:
//   clk            in   single clock, all state changes on the rising edge
//   areset         in   asynchronous active-high reset
//   in_valid       in   in_bit carries a sample this cycle
//   in_bit         in   mismatch bit (1 = a != b)
//   clear          in   synchronous clear of all statistics and the alarm
//   busy           out  FSM is not in IDLE
//   alarm          out  sticky run-threshold alarm (FSM in ALARM)
//   run_len        out  current consecutive-mismatch run, saturating
//   mismatch_total out  total mismatches since reset/clear, saturating
//   window_count   out  mismatches in the last completed window
//   window_done    out  one-cycle pulse when window_count updates
//
// Handshake: there is no back-pressure. A sample is consumed on every rising
// edge where in_valid=1 and clear=0; results of that sample are visible on
// the outputs in the following cycle. Priority: areset > clear > in_valid.
//
// All outputs are driven straight from flops. busy and alarm are registered
// from the next-state value so that they change in the same cycle as the
// state register itself.

module xor_mismatch_monitor #(
    parameter int CNT_W      = 8,
    parameter int RUN_THRESH = 4,
    parameter int WINDOW     = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             busy,
    output logic             alarm,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] mismatch_total,
    output logic [CNT_W-1:0] window_count,
    output logic             window_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(RUN_THRESH);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] run_q, run_next;
    logic [CNT_W-1:0] total_q, total_next;
    logic [CNT_W-1:0] pos_q, pos_next;
    logic [CNT_W-1:0] acc_q, acc_next;
    logic [CNT_W-1:0] wcount_q, wcount_next;
    logic             wdone_q, wdone_next;
    logic             busy_q, alarm_q;

    // State and statistics registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            run_q    <= '0;
            total_q  <= '0;
            pos_q    <= '0;
            acc_q    <= '0;
            wcount_q <= '0;
            wdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state    <= state_next;
            run_q    <= run_next;
            total_q  <= total_next;
            pos_q    <= pos_next;
            acc_q    <= acc_next;
            wcount_q <= wcount_next;
            wdone_q  <= wdone_next;
            busy_q   <= (state_next != IDLE);
            alarm_q  <= (state_next == ALARM);
        end
    end

    // Next-state and statistics update.
    always_comb begin
        state_next  = state;
        run_next    = run_q;
        total_next  = total_q;
        pos_next    = pos_q;
        acc_next    = acc_q;
        wcount_next = wcount_q;
        wdone_next  = 1'b0;

        if (clear) begin
            // A sample arriving together with clear is dropped.
            state_next  = IDLE;
            run_next    = '0;
            total_next  = '0;
            pos_next    = '0;
            acc_next    = '0;
            wcount_next = '0;
        end else if (in_valid) begin
            if (in_bit) begin
                run_next   = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
                total_next = (total_q == CNT_MAX) ? total_q : total_q + 1'b1;
            end else begin
                run_next = '0;
            end

            // Only valid samples move the window; idle cycles just stretch it.
            if (pos_q == WIN_LAST) begin
                wcount_next = acc_q + CNT_W'(in_bit);
                wdone_next  = 1'b1;
                pos_next    = '0;
                acc_next    = '0;
            end else begin
                pos_next = pos_q + 1'b1;
                acc_next = acc_q + CNT_W'(in_bit);
            end

            // The alarm compare uses the updated run. Once in ALARM the
            // state is sticky, so a run held at saturation cannot re-trigger.
            case (state)
                IDLE, MONITOR: state_next = (run_next == THRESH_V) ? ALARM : MONITOR;
                ALARM:         state_next = ALARM;
                default:       state_next = IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign alarm          = alarm_q;
    assign run_len        = run_q;
    assign mismatch_total = total_q;
    assign window_count   = wcount_q;
    assign window_done    = wdone_q;

endmodule

// File: doc/xor_mismatch_monitor.md
Name: xor_mismatch_monitor

Overview:
- Downstream consumer of the registered XOR stage output, i.e. the per-cycle mismatch bit a^b.
- Accumulates mismatch statistics: running total, current consecutive-mismatch run, and per-window mismatch count.
- Raises a sticky alarm when a mismatch run reaches a threshold.
- Feeds status/debug logic; the upstream XOR stage is unchanged.

Parameters:
- CNT_W, 8: width of all counters; must satisfy 2^CNT_W-1 >= WINDOW and 2^CNT_W-1 >= RUN_THRESH.
- RUN_THRESH, 4: consecutive valid mismatches that trigger alarm; must be >= 1.
- WINDOW, 16: valid samples per statistics window; must be >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- areset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bit is a sample this cycle.
- in_bit  input  1  mismatch bit from the XOR stage (1 = a != b).
- clear  input  1  synchronous clear of all statistics and alarm.
- busy  output  1  FSM not in IDLE.
- alarm  output  1  sticky run-threshold alarm.
- run_len  output  CNT_W  current consecutive-mismatch run length, saturating.
- mismatch_total  output  CNT_W  total mismatches since reset/clear, saturating.
- window_count  output  CNT_W  mismatches in the last completed window.
- window_done  output  1  one-cycle pulse when window_count updates.

Behaviour:
- Interface: one clock, clk; reset areset is asynchronous and active-high. While areset=1, every register and output is 0 and the FSM is in IDLE, with no clock needed.
- All outputs are registered. Results of a sample appear the cycle after the clock edge that captures it (latency 1).
- Priority per edge: areset > clear > in_valid.
- clear=1: all counters, window position/accumulator, alarm, window_count and window_done go to 0; FSM goes to IDLE. A same-cycle valid sample is discarded.
- in_valid=0: no counter, window or FSM change; window_done returns to 0.
- FSM states:
  - IDLE (busy=0): no valid sample since reset/clear. A valid sample moves to MONITOR and that sample is counted.
  - MONITOR (busy=1): normal accumulation. When the updated run_len equals RUN_THRESH, moves to ALARM; alarm=1 in the same cycle run_len shows RUN_THRESH.
  - ALARM (busy=1, alarm=1): sticky. Counting and windows continue. Only clear or areset exits.
  - With RUN_THRESH=1, the first mismatch goes IDLE -> ALARM directly.
- run_len on a valid sample:
  - in_bit=1: increments, saturating at 2^CNT_W-1.
  - in_bit=0: goes to 0.
  - The alarm compare uses the updated value; a saturated run does not re-trigger.
- mismatch_total: increments on valid in_bit=1, saturating at 2^CNT_W-1; never wraps.
- Window logic:
  - An internal position counter runs 0..WINDOW-1 and an accumulator counts mismatches; both advance on valid samples only.
  - On the valid sample where position==WINDOW-1: window_count <= acc + in_bit, window_done=1 for exactly one cycle, position and acc return to 0.
  - Gaps in in_valid stretch a window; they never close one.
- window_done is 0 on every other cycle, including back-to-back windows separated by invalid cycles.
- areset asserted mid-window or mid-run: all partial state is lost; the first valid sample after release starts a fresh window at position 0.

Test Plan:
- Async reset: mid-run (run_len=3, total=7), pulse areset between edges -> all outputs 0 before the next rising edge; busy=0.
- Threshold (RUN_THRESH=4): valid bits 1,1,1,1,0 -> run_len 1,2,3,4,0; alarm=1 from the 4th sample's cycle and stays 1 after the 0; total=4. Pattern 1,1,1,0,1,1,1 -> no alarm.
- Window (WINDOW=16): 16 valid samples with 5 ones, interleaved with 6 invalid cycles -> one window_done pulse after the 16th valid edge, window_count=5; the next 16 samples with 0 ones -> window_count=0, pulse again.
- Saturation (CNT_W=4, RUN_THRESH=4, WINDOW=8): 20 consecutive valid ones -> mismatch_total=15, run_len=15, alarm=1, no wrap; window_count=8 at each window end.
- Clear priority: clear=1 with in_valid=1, in_bit=1 while in ALARM -> next cycle all counters 0, alarm=0, busy=0. The next valid sample sets busy=1 and counts normally.
- Idle transition: after reset, valid in_bit=0 -> busy=1, run_len=0, total=0; in_valid held 0 for 10 cycles -> no state change.
